// File: rtl/mac_result_requant.sv
// Ping-pong output stage behind the MAC array: buffers two accumulator tiles,
// requantizes (round-half-up shift, signed saturation) and streams one row per beat.
module mac_result_requant #(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT_W   = 5,
    localparam int RIDX_W   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [M-1:0][N-1:0][31:0]          D_i,
    input  logic [SHIFT_W-1:0]                 shift_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    output logic [N-1:0][OUT_WIDTH-1:0]        row_o,
    output logic [RIDX_W-1:0]                  row_idx_o,
    output logic                               last_o,
    output logic                               sat_o,
    output logic                               valid_o,
    input  logic                               ready_i
);

    localparam logic signed [32:0] SAT_MAX = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
    localparam logic signed [32:0] SAT_MIN = -(33'sd1 <<< (OUT_WIDTH - 1));

    logic [M-1:0][N-1:0][31:0] tile_q  [2];
    logic [SHIFT_W-1:0]        shift_q [2];
    logic [1:0]                occ_q;
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [RIDX_W-1:0]         row_q;

    logic accept;
    logic drain;
    logic row_last;
    logic drain_last;

    // Returns {clipped, y}; the 33-bit intermediate cannot overflow on the rounding add.
    function automatic logic [OUT_WIDTH:0] requant(input logic [31:0] x,
                                                   input logic [SHIFT_W-1:0] s);
        logic signed [32:0] xe;
        logic signed [32:0] y33;
        logic [31:0]        s32;
        xe  = {x[31], x};
        s32 = 32'(s);
        if (s32 == 32'd0)
            y33 = xe;
        else if (s32 >= 32'd32)
            y33 = {33{x[31]}};
        else
            y33 = (xe + (33'sd1 <<< (s32 - 32'd1))) >>> s32;

        if (y33 > SAT_MAX)
            requant = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        else if (y33 < SAT_MIN)
            requant = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        else
            requant = {1'b0, y33[OUT_WIDTH-1:0]};
    endfunction

    assign ready_o    = (occ_q != 2'd2);
    assign valid_o    = (occ_q != 2'd0);
    assign accept     = valid_i & ready_o;
    assign drain      = valid_o & ready_i;
    assign row_last   = (row_q == RIDX_W'(M - 1));
    assign drain_last = drain & row_last;
    assign row_idx_o  = row_q;
    assign last_o     = valid_o & row_last;

    // Tile storage is data-only; validity lives entirely in occ_q.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tile_q[wr_ptr_q]  <= D_i;
            shift_q[wr_ptr_q] <= shift_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            row_q    <= '0;
        end else begin
            if (accept)
                wr_ptr_q <= ~wr_ptr_q;
            if (drain) begin
                if (row_last) begin
                    row_q    <= '0;
                    rd_ptr_q <= ~rd_ptr_q;
                end else begin
                    row_q <= row_q + 1'b1;
                end
            end
            if (accept && !drain_last)
                occ_q <= occ_q + 2'd1;
            else if (!accept && drain_last)
                occ_q <= occ_q - 2'd1;
        end
    end

    // Outputs are gated by valid_o so unwritten slots never leak after reset.
    always_comb begin
        logic [OUT_WIDTH:0] rq;
        row_o = '0;
        sat_o = 1'b0;
        rq    = '0;
        for (int unsigned c = 0; c < N; c++) begin
            rq = requant(tile_q[rd_ptr_q][row_q][c], shift_q[rd_ptr_q]);
            if (valid_o) begin
                row_o[c] = rq[OUT_WIDTH-1:0];
                sat_o    = sat_o | rq[OUT_WIDTH];
            end
        end
    end

endmodule
